// File: rtl/x_stream_tx_pkg.sv
// Shared types and default sizing for the x-stream transmitter.
package x_stream_tx_pkg;

    // Address bits needed to index a bank of the given depth (minimum 1).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned LENX_DEF  = 32;
    localparam int unsigned ADDRX_DEF = addr_width(LENX_DEF);

    // Lifecycle of one ping-pong bank.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        SENDING = 2'd2
    } bank_state_e;

endpackage

// File: rtl/memory.sv
// Single-port-write / single-port-read bank with 1-cycle synchronous read.
// rdata holds its last value while re is low.
module memory #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LENX  = 32,
    parameter int unsigned ADDRX = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDRX-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [ADDRX-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [LENX];
    logic [WIDTH-1:0] rdata_q;

    // Synchronous write and registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/x_stream_tx.sv
// Double-buffered stream transmitter: host fills one bank while the other
// drains into the layer's valid/ready input. Reads run up to two words
// ahead (memory output stage + output register) to hide memory latency.
module x_stream_tx
    import x_stream_tx_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned LENX  = LENX_DEF,
    parameter int unsigned ADDRX = ADDRX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] h_data,
    input  logic             h_valid,
    output logic             h_ready,
    output logic [WIDTH-1:0] m_data_out_x,
    output logic             m_valid_x,
    input  logic             m_ready_x
);

    localparam logic [ADDRX-1:0] LAST_ADDR = ADDRX'(LENX - 1);

    bank_state_e      state_q [2];
    bank_state_e      state_d [2];
    logic             wbank_q, wbank_d;
    logic [ADDRX-1:0] waddr_q, waddr_d;
    logic             rbank_q, rbank_d;
    logic [ADDRX-1:0] raddr_q, raddr_d;
    logic             h_ready_q, h_ready_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q, s1_last_d;
    logic             s1_bank_q, s1_bank_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_bank_q, out_bank_d;

    logic [1:0]       mem_we;
    logic [1:0]       mem_re;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] s1_data;
    logic             h_fire;
    logic             out_fire;
    logic             out_load;
    logic             s1_move;
    logic             issue;

    memory #(.WIDTH(WIDTH), .LENX(LENX), .ADDRX(ADDRX)) u_bank0 (
        .clk   (clk),
        .we    (mem_we[0]),
        .waddr (waddr_q),
        .wdata (h_data),
        .re    (mem_re[0]),
        .raddr (raddr_q),
        .rdata (rdata0)
    );

    memory #(.WIDTH(WIDTH), .LENX(LENX), .ADDRX(ADDRX)) u_bank1 (
        .clk   (clk),
        .we    (mem_we[1]),
        .waddr (waddr_q),
        .wdata (h_data),
        .re    (mem_re[1]),
        .raddr (raddr_q),
        .rdata (rdata1)
    );

    // Next-state for load side, read issue, skid stage and bank states.
    always_comb begin
        state_d     = state_q;
        wbank_d     = wbank_q;
        waddr_d     = waddr_q;
        rbank_d     = rbank_q;
        raddr_d     = raddr_q;
        s1_last_d   = s1_last_q;
        s1_bank_d   = s1_bank_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_bank_d  = out_bank_q;
        mem_we      = '0;
        mem_re      = '0;

        s1_data  = s1_bank_q ? rdata1 : rdata0;
        h_fire   = h_valid && h_ready_q;
        out_fire = out_valid_q && m_ready_x;
        out_load = !out_valid_q || m_ready_x;
        s1_move  = s1_valid_q && out_load;
        issue    = ((state_q[rbank_q] == FULL) || (state_q[rbank_q] == SENDING))
                   && (!s1_valid_q || s1_move);

        // Load side: write word, close the bank on its last address.
        if (h_fire) begin
            mem_we[wbank_q] = 1'b1;
            if (waddr_q == LAST_ADDR) begin
                state_d[wbank_q] = FULL;
                waddr_d          = '0;
                wbank_d          = ~wbank_q;
            end else begin
                waddr_d = waddr_q + ADDRX'(1);
            end
        end

        // Read issue: one address per cycle while the skid stage has room.
        if (issue) begin
            mem_re[rbank_q]  = 1'b1;
            state_d[rbank_q] = SENDING;
            s1_last_d        = (raddr_q == LAST_ADDR);
            s1_bank_d        = rbank_q;
            if (raddr_q == LAST_ADDR) begin
                raddr_d = '0;
                rbank_d = ~rbank_q;
            end else begin
                raddr_d = raddr_q + ADDRX'(1);
            end
        end
        s1_valid_d = issue || (s1_valid_q && !s1_move);

        // Output register refills from the memory stage when empty or accepted.
        if (out_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = s1_data;
                out_last_d = s1_last_q;
                out_bank_d = s1_bank_q;
            end
        end

        // Bank is released once its last word has been taken by the layer.
        if (out_fire && out_last_q) begin
            state_d[out_bank_q] = EMPTY;
        end

        h_ready_d = (state_d[wbank_d] == EMPTY);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q[0]  <= EMPTY;
            state_q[1]  <= EMPTY;
            wbank_q     <= 1'b0;
            waddr_q     <= '0;
            rbank_q     <= 1'b0;
            raddr_q     <= '0;
            h_ready_q   <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_bank_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wbank_q     <= wbank_d;
            waddr_q     <= waddr_d;
            rbank_q     <= rbank_d;
            raddr_q     <= raddr_d;
            h_ready_q   <= h_ready_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_bank_q   <= s1_bank_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_bank_q  <= out_bank_d;
        end
    end

    assign h_ready      = h_ready_q;
    assign m_valid_x    = out_valid_q;
    assign m_data_out_x = out_data_q;

endmodule

// File: tb/tb_x_stream_tx.sv
// Directed self-checking bench for x_stream_tx.
module tb_x_stream_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] h_data;
    logic        h_valid;
    logic        h_ready;
    logic [15:0] m_data_out_x;
    logic        m_valid_x;
    logic        m_ready_x;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] got_q[$];
    int          gcyc_q[$];

    logic rdy_mode  = 1'b0;
    logic rdy_force = 1'b0;
    logic rnd_bit   = 1'b0;

    logic        stall_prev = 1'b0;
    logic [15:0] prev_data  = '0;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dexp;
    } vec_t;
    vec_t tbl[32];

    x_stream_tx dut (
        .clk          (clk),
        .reset        (reset),
        .h_data       (h_data),
        .h_valid      (h_valid),
        .h_ready      (h_ready),
        .m_data_out_x (m_data_out_x),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    always_comb m_ready_x = rdy_mode ? rnd_bit : rdy_force;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return 32'(got_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // Transfer monitor and hold-while-stalled checker.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(m_valid_x), 32'd1);
                check("hold_data", 32'(m_data_out_x), 32'(prev_data));
            end
            if (m_valid_x && m_ready_x) begin
                got_q.push_back(m_data_out_x);
                gcyc_q.push_back(cyc);
            end
            stall_prev = m_valid_x && !m_ready_x;
            prev_data  = m_data_out_x;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_q.delete();
        gcyc_q.delete();
    endtask

    // Present one host word and hold it until accepted.
    task automatic load_word(input logic [15:0] d);
        logic acc;
        int   n;
        n       = 0;
        h_valid = 1'b1;
        h_data  = d;
        do begin
            acc = h_ready;
            step();
            n++;
        end while (!acc && n < 200);
        if (!acc) timeout_fail("load_accept");
    endtask

    task automatic wait_got(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (got_q.size() < n) timeout_fail("wait_output");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;

        // Sign/width vector table: outputs must be bit-identical to inputs.
        tbl[0] = '{16'h8000, 16'h8000};
        tbl[1] = '{16'h7FFF, 16'h7FFF};
        tbl[2] = '{16'hFFFF, 16'hFFFF};
        tbl[3] = '{16'h0000, 16'h0000};
        tbl[4] = '{16'h0001, 16'h0001};
        tbl[5] = '{16'h5555, 16'h5555};
        tbl[6] = '{16'hAAAA, 16'hAAAA};
        tbl[7] = '{16'hFFFE, 16'hFFFE};
        for (int i = 8; i < 32; i++) tbl[i] = '{16'(16'hC000 + i * 257), 16'(16'hC000 + i * 257)};

        reset   = 1'b1;
        h_valid = 1'b0;
        h_data  = '0;
        repeat (3) step();
        check("rst_h_ready", 32'(h_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid_x), 32'd0);
        check("rst_m_data", 32'(m_data_out_x), 32'd0);
        reset = 1'b0;
        step();

        // Single vector with latency check.
        clear_got();
        rdy_force = 1'b1;
        for (int i = 0; i < 32; i++) load_word(16'(i));
        h_valid = 1'b0;
        check("lat_t0_valid", 32'(m_valid_x), 32'd0);
        step();
        check("lat_t1_valid", 32'(m_valid_x), 32'd0);
        step();
        check("lat_t2_valid", 32'(m_valid_x), 32'd1);
        check("lat_t2_data", 32'(m_data_out_x), 32'd0);
        wait_got(32, 100);
        repeat (4) step();
        check("single_count", 32'(got_q.size()), 32'd32);
        for (int i = 0; i < 32; i++) check("single_data", got_at(i), 32'(i));
        if (got_q.size() >= 32)
            for (int i = 1; i < 32; i++) check("single_gap", 32'(gcyc_q[i] - gcyc_q[i-1]), 32'd1);
        check("single_h_ready", 32'(h_ready), 32'd1);

        // Ping-pong: three vectors loaded back to back.
        clear_got();
        for (int v = 0; v < 3; v++)
            for (int i = 0; i < 32; i++) load_word(16'(100 * (v + 1) + i));
        h_valid = 1'b0;
        wait_got(96, 300);
        for (int v = 0; v < 3; v++)
            for (int i = 0; i < 32; i++) check("pp_data", got_at(v * 32 + i), 32'(100 * (v + 1) + i));
        if (got_q.size() >= 96)
            for (int i = 1; i < 96; i++)
                if (i != 64) check("pp_gap", 32'(gcyc_q[i] - gcyc_q[i-1]), 32'd1);

        // Random backpressure over two vectors.
        clear_got();
        rdy_mode = 1'b1;
        for (int i = 0; i < 64; i++) load_word(16'(i * 37 + 5));
        h_valid = 1'b0;
        wait_got(64, 1000);
        rdy_mode = 1'b0;
        repeat (4) step();
        check("bp_count", 32'(got_q.size()), 32'd64);
        for (int i = 0; i < 64; i++) check("bp_data", got_at(i), 32'(16'(i * 37 + 5)));

        // Full stall: both banks occupied, then release.
        clear_got();
        rdy_force = 1'b0;
        for (int i = 0; i < 64; i++) load_word(16'(2000 + i));
        h_valid = 1'b0;
        check("stall_h_ready_low", 32'(h_ready), 32'd0);
        check("stall_m_valid", 32'(m_valid_x), 32'd1);
        check("stall_m_data", 32'(m_data_out_x), 32'd2000);
        rdy_force = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            check("stall_h_ready", 32'(h_ready), 32'(i == 31));
        end
        wait_got(64, 200);
        for (int i = 0; i < 64; i++) check("stall_data", got_at(i), 32'(2000 + i));

        // Sign/width table.
        clear_got();
        for (int i = 0; i < 32; i++) load_word(tbl[i].din);
        h_valid = 1'b0;
        wait_got(32, 100);
        for (int i = 0; i < 32; i++) check("sign_data", got_at(i), 32'(tbl[i].dexp));

        // Reset mid-send with a partially loaded second bank.
        clear_got();
        rdy_force = 1'b0;
        for (int i = 0; i < 32; i++) load_word(16'(3000 + i));
        for (int i = 0; i < 5; i++) load_word(16'(4000 + i));
        h_valid   = 1'b0;
        rdy_force = 1'b1;
        k = 0;
        while (got_q.size() < 10 && k < 100) begin
            step();
            k++;
        end
        if (got_q.size() < 10) timeout_fail("rms_wait");
        reset = 1'b1;
        step();
        check("rms_m_valid", 32'(m_valid_x), 32'd0);
        check("rms_h_ready", 32'(h_ready), 32'd1);
        check("rms_m_data", 32'(m_data_out_x), 32'd0);
        check("rms_sent", 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) check("rms_pre_data", got_at(i), 32'(3000 + i));
        reset = 1'b0;
        step();
        clear_got();
        for (int i = 0; i < 32; i++) load_word(16'(5000 + i));
        h_valid = 1'b0;
        wait_got(32, 100);
        repeat (6) step();
        check("rms_count", 32'(got_q.size()), 32'd32);
        for (int i = 0; i < 32; i++) check("rms_data", got_at(i), 32'(5000 + i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/x_stream_tx.md
# x_stream_tx

Double-buffered stream transmitter that feeds convolution layers through their `s_data_in_x` / `s_valid_x` / `s_ready_x` input port. A host-side write port loads one input vector of `LENX` words into a ping-pong buffer. The transmit side replays each completed vector, in order, as a valid/ready stream. While one bank drains into the layer, the other bank fills, so back-to-back vectors stream without gaps.

## Interface
- `WIDTH`, 16, data word width (signed)
- `LENX`, 32, words per vector
- `ADDRX`, 5, bank address width; `2**ADDRX >= LENX`
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `h_data`  in  WIDTH  host load data, signed
- `h_valid`  in  1  host word present
- `h_ready`  out  1  transmitter accepts host word
- `m_data_out_x`  out  WIDTH  stream data to the layer's `s_data_in_x`
- `m_valid_x`  out  1  stream word valid, to the layer's `s_valid_x`
- `m_ready_x`  in  1  layer accepts word, from the layer's `s_ready_x`

## Operation
- Storage: two banks (0, 1), each `LENX` words. Each bank has a state:
  - EMPTY: writable.
  - FULL: all `LENX` words written, not yet sent.
  - SENDING: transmit side is draining it.
- Load side:
  - Write pointer `wbank`, write address `waddr`.
  - A host word is accepted on `h_valid && h_ready`. It is written to `wbank[waddr]` and `waddr` increments.
  - On the word with `waddr == LENX-1`: the bank goes FULL, `waddr` returns to 0, `wbank` toggles.
  - `h_ready = (state[wbank] == EMPTY)`. It is a registered/state-derived signal with no combinational path from `h_valid`.
- Transmit side:
  - Read pointer `rbank`, read address `raddr`.
  - When `state[rbank] == FULL`, the bank goes SENDING and words are read in address order 0..`LENX-1`.
  - A word transfers on `m_valid_x && m_ready_x`.
  - After the transfer of word `LENX-1`, the bank goes EMPTY and `rbank` toggles.
- Ordering:
  - Vectors leave in load order.
  - Words leave in the same order they arrived.
  - Values are bit-exact; there is no arithmetic.
- AXI-style stream rules:
  - Once `m_valid_x` is 1, `m_data_out_x` and `m_valid_x` hold until `m_ready_x`.
  - `m_valid_x` never depends combinationally on `m_ready_x`.
- Simultaneous events:
  - A bank freed (SENDING to EMPTY) in cycle t while the load side waits on it: `h_ready` rises in cycle t+1.
  - Load completing into one bank while the other is draining: both proceed independently in the same cycle.
- Mid-vector reset: any partially loaded or partially sent vector is discarded. Both banks return to EMPTY.

## Timing
- Reset values:
  - `h_ready = 1`, `m_valid_x = 0`, `m_data_out_x = 0`.
  - `wbank = rbank = 0`, `waddr = raddr = 0`, both banks EMPTY.
- Bank memories have a 1-cycle synchronous read.
- Output uses a 2-entry skid stage (read-issue register plus output register). This provides a read-ahead of up to 2 words and sustains the full stream rate against the 1-cycle memory latency.
- Latency:
  - Host word `LENX-1` accepted at edge t.
  - First word of that vector is valid from cycle t+2, provided the transmit side is idle.
- Throughput:
  - With `m_ready_x` held 1, one word per cycle within a vector.
  - Zero bubble between consecutive vectors when the next bank is already FULL.
- Load side takes one word per cycle while `h_ready` is 1.
- Backpressure: `m_ready_x` low for N cycles stalls output exactly N cycles. No word is lost or duplicated.
- Both banks FULL or SENDING: `h_ready = 0` until the drained bank's last word transfers, then rises one cycle later.

## Structure
- Shared package holds:
  - the bank state enum: EMPTY, FULL, SENDING;
  - default `WIDTH`/`LENX`/`ADDRX` constants;
  - the `clog2`-based address width helper.
- Sub-module: reuse the codebase's `memory #(WIDTH, LENX, ADDRX)` twice, one per bank (synchronous write and read).
- Top holds:
  - the load FSM;
  - the transmit FSM with skid stage;
  - the per-bank state registers.

## Test plan
- Single vector: load words 0..31 with `h_valid` constant 1, `m_ready_x=1` -> outputs 0..31 consecutively. First output is 2 cycles after the last load. Then `h_ready` stays 1.
- Ping-pong: load three vectors (values 100+i, 200+i, 300+i) continuously while the sink is always ready -> 96 outputs in order. No bubble between vectors 1 and 2. `h_ready` drops only when both banks are occupied.
- Backpressure: random `m_ready_x` (50%) over two vectors -> data held stable while valid and not ready. Output equals input sequence exactly, with no gaps or duplicates.
- Full stall: load two vectors with `m_ready_x=0` -> `h_ready=0` after 64 accepted words, `m_valid_x=1` showing word 0. Release ready -> `h_ready` rises the cycle after word 31 transfers.
- Sign/width: load 16'h8000, 16'h7FFF, -1 -> the same bit patterns emerge unchanged.
- Reset mid-send: assert `reset` after 10 words are sent -> next cycle `m_valid_x=0`, `h_ready=1`. A fresh vector then streams from its own word 0.
